wb_write_queue: RTL and testbench

//  Write-back queue in front of the 32x32 register file write port.

---
 rtl/wb_write_queue.sv | 130 +++++++++++++
 tb/tb_wb_write_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Write-back queue sitting in front of the register file's single write port.
// Requests (dest, value) from the write-back stage are buffered in order and
// drained oldest-first, at most one per cycle. Two forwarding lookups let decode
// see pending data before it reaches the register file.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   in_valid/in_ready           request handshake (in_ready = !full)
//   in_dest, in_value           request payload
//   drain_en                    head may be written to the register file this cycle
//   rf_write_en/rf_dest/
//   rf_write_value              register file write port (zero when empty)
//   src1/src2 -> hit1/fwd1,
//               hit2/fwd2       youngest-match forwarding lookups
//   count, empty, full          occupancy status
module wb_write_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_dest,
    input  logic [DATA_W-1:0]          in_value,
    input  logic                       drain_en,
    output logic                       rf_write_en,
    output logic [ADDR_W-1:0]          rf_dest,
    output logic [DATA_W-1:0]          rf_write_value,
    input  logic [ADDR_W-1:0]          src1,
    input  logic [ADDR_W-1:0]          src2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [DATA_W-1:0]          fwd1,
    output logic [DATA_W-1:0]          fwd2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] dest_q  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              push, pop;
    logic [PTR_W-1:0]  age_idx [DEPTH];

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign in_ready = !full;

    assign push = in_valid && !full;
    assign pop  = drain_en && !empty;

    assign rf_write_en    = pop;
    assign rf_dest        = empty ? '0 : dest_q[head_q];
    assign rf_write_value = empty ? '0 : value_q[head_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            count_q <= count_d;
            // Push and pop never share a slot: that would need count 0 (no pop)
            // or count DEPTH (no push).
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
        end
    end

    // Payload needs no reset; valid bits and the empty-gated outputs hide it.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail_q]  <= in_dest;
            value_q[tail_q] <= in_value;
        end
    end

    // Slot indices ordered oldest (head) to youngest.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_idx[i] = head_q + PTR_W'(i);
        end
    end

    // Scanning oldest to youngest lets the last match win, i.e. the youngest.
    // The incoming request is deliberately not searched.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[age_idx[i]] && (dest_q[age_idx[i]] == src1)) begin
                hit1 = 1'b1;
                fwd1 = value_q[age_idx[i]];
            end
            if (valid_q[age_idx[i]] && (dest_q[age_idx[i]] == src2)) begin
                hit2 = 1'b1;
                fwd2 = value_q[age_idx[i]];
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dest;
    logic [31:0] in_value;
    logic        drain_en;
    logic        rf_write_en;
    logic [4:0]  rf_dest;
    logic [31:0] rf_write_value;
    logic [4:0]  src1, src2;
    logic        hit1, hit2;
    logic [31:0] fwd1, fwd2;
    logic [2:0]  count;
    logic        empty, full;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] value;
    } entry_t;

    entry_t model_q[$];
    logic [31:0] fill_vals [4];

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_dest        (in_dest),
        .in_value       (in_value),
        .drain_en       (drain_en),
        .rf_write_en    (rf_write_en),
        .rf_dest        (rf_dest),
        .rf_write_value (rf_write_value),
        .src1           (src1),
        .src2           (src2),
        .hit1           (hit1),
        .hit2           (hit2),
        .fwd1           (fwd1),
        .fwd2           (fwd2),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest queued entry whose dest matches src.
    task automatic model_lookup(input logic [4:0] src, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].dest == src) begin
                hit = 1'b1;
                val = model_q[i].value;
                break;
            end
        end
    endtask

    task automatic check_all();
        logic        h;
        logic [31:0] v;
        int          n;
        n = model_q.size();
        chk("in_ready", in_ready, n < DEPTH);
        chk("rf_write_en", rf_write_en, drain_en && n > 0);
        chk("rf_dest", rf_dest, n > 0 ? model_q[0].dest : 5'd0);
        chk("rf_write_value", rf_write_value, n > 0 ? model_q[0].value : 32'd0);
        model_lookup(src1, h, v);
        chk("hit1", hit1, h);
        chk("fwd1", fwd1, v);
        model_lookup(src2, h, v);
        chk("hit2", hit2, h);
        chk("fwd2", fwd2, v);
        chk("count", count, n);
        chk("empty", empty, n == 0);
        chk("full", full, n == DEPTH);
    endtask

    task automatic drive(input logic v, input logic [4:0] d, input logic [31:0] val,
                         input logic dr, input logic [4:0] s1, input logic [4:0] s2);
        in_valid = v;
        in_dest  = d;
        in_value = val;
        drain_en = dr;
        src1     = s1;
        src2     = s2;
    endtask

    // Check at the negedge, then advance the model across the posedge.
    task automatic tick();
        logic do_push, do_pop;
        entry_t e;
        @(negedge clk);
        check_all();
        do_push = in_valid && model_q.size() < DEPTH;
        do_pop  = drain_en && model_q.size() > 0;
        e.dest  = in_dest;
        e.value = in_value;
        @(posedge clk);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(e);
        #1;
    endtask

    initial begin
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_rf_write_en", rf_write_en, 0);
        chk("reset_hit1", hit1, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single write, no same-cycle bypass.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 5'd6);
        #2 chk("single_no_bypass", rf_write_en, 0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);
        #2;
        chk("single_wen", rf_write_en, 1);
        chk("single_dest", rf_dest, 5);
        chk("single_value", rf_write_value, 32'hDEAD_BEEF);
        chk("single_fwd_pop", fwd1, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        #2 chk("single_empty", empty, 1);
        tick();

        // Fill, overflow attempt, drain in order.
        for (int i = 0; i < 4; i++) begin
            fill_vals[i] = $urandom;
            drive(1'b1, 5'(10 + i), fill_vals[i], 1'b0, 5'd0, 5'd0);
            tick();
        end
        drive(1'b1, 5'd20, 32'h1234_5678, 1'b0, 5'd0, 5'd0);
        #2;
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        chk("fill_in_ready", in_ready, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
            #2;
            chk("drain_dest", rf_dest, 10 + i);
            chk("drain_value", rf_write_value, fill_vals[i]);
            tick();
        end
        chk("drain_empty", empty, 1);

        // Forwarding picks the youngest match.
        drive(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd8, 32'd9, 1'b0, 5'd7, 5'd8);
        #2;
        chk("fwd_hit1", hit1, 1);
        chk("fwd_val1", fwd1, 2);
        chk("fwd_hit2_incoming", hit2, 0);
        chk("fwd_val2_incoming", fwd2, 0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd8);
        tick();

        // Push+pop at count 2.
        drive(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd3, 5'd7);
        #2 chk("pushpop_pre_count", count, 2);
        tick();
        chk("pushpop_count", count, 2);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        tick();
        tick();

        // Reset with 3 pending.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i + 1), $urandom, 1'b0, 5'd0, 5'd0);
            tick();
        end
        chk("pre_reset_count", count, 3);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_wen", rf_write_en, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_hit1", hit1, 0);
        model_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 5'd0);
        #2 chk("postrst_no_wen", rf_write_en, 0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        #2;
        chk("postrst_wen", rf_write_en, 1);
        chk("postrst_dest", rf_dest, 0);
        chk("postrst_value", rf_write_value, 32'h55);
        tick();

        // Random mixed traffic, exercises wrap-around and duplicate dests.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
